// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              o_fifo_full;
  logic              o_fifo_empty;
  logic              o_almost_full;
  logic              o_almost_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, o_fifo_full, o_fifo_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, o_fifo_full, o_fifo_empty, o_almost_full,
           o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO with sticky over/underflow flags
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = (1 << ADDR_W) - 2,
  parameter int AEMPTY_TH = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave fifo
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              full, empty, wr_acc, rd_acc;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign wr_acc = fifo.wr_en && !full;
  assign rd_acc = fifo.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    ovf_d = ovf_q | (fifo.wr_en & full);
    unf_d = unf_q | (fifo.rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= fifo.wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign fifo.rd_data  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign fifo.rd_valid = !empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign fifo.rd_data  = rd_data_q;
  assign fifo.rd_valid = rd_valid_q;
`endif

  assign fifo.o_count        = count;
  assign fifo.o_fifo_full    = full;
  assign fifo.o_fifo_empty   = empty;
  assign fifo.o_almost_full  = (count >= AFULL_C);
  assign fifo.o_almost_empty = (count <= AEMPTY_C);
  assign fifo.o_overflow     = ovf_q;
  assign fifo.o_underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk (clk),
    .rst (rst),
    .fifo(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: occupancy is simply the queue length.
  bit [7:0] mq[$];
  bit       m_ovf, m_unf, m_rv;
  bit [7:0] m_rd;

  typedef struct {
    bit       rst, wr, rd;
    bit [7:0] din;
    int       cnt;
    bit       emp, ful, ovf, unf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit w, bit rd, bit [7:0] d);
    rst = r;
    bus.wr_en = w;
    bus.rd_en = rd;
    bus.wr_data = d;
  endtask

  task automatic tick();
    bit wa, ra;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    end else begin
      wa = bus.wr_en && (mq.size() < DEPTH);
      ra = bus.rd_en && (mq.size() > 0);
      if (bus.wr_en && mq.size() == DEPTH) m_ovf = 1;
      if (bus.rd_en && mq.size() == 0) m_unf = 1;
      m_rv = ra;
      if (ra) begin
        m_rd = mq[0];
        void'(mq.pop_front());
      end
      if (wa) mq.push_back(bus.wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".count"}, 32'(bus.o_count), 32'(mq.size()));
    chk({tag, ".full"}, 32'(bus.o_fifo_full), 32'(mq.size() == DEPTH));
    chk({tag, ".empty"}, 32'(bus.o_fifo_empty), 32'(mq.size() == 0));
    chk({tag, ".afull"}, 32'(bus.o_almost_full), 32'(mq.size() >= 14));
    chk({tag, ".aempty"}, 32'(bus.o_almost_empty), 32'(mq.size() <= 2));
    chk({tag, ".ovf"}, 32'(bus.o_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.o_underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".rvalid"}, 32'(bus.rd_valid), 32'(mq.size() > 0));
    chk({tag, ".rdata"}, 32'(bus.rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
`else
    chk({tag, ".rvalid"}, 32'(bus.rd_valid), 32'(m_rv));
    chk({tag, ".rdata"}, 32'(bus.rd_data), 32'(m_rd));
`endif
  endtask

  initial begin
    drive(1, 0, 0, 8'h00);

    tbl[0] = '{rst:1, wr:0, rd:0, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:0};
    tbl[1] = '{rst:0, wr:0, rd:1, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:1};
    tbl[2] = '{rst:0, wr:1, rd:0, din:8'h5C, cnt:1, emp:0, ful:0, ovf:0, unf:1};
    tbl[3] = '{rst:0, wr:1, rd:1, din:8'h11, cnt:1, emp:0, ful:0, ovf:0, unf:1};
    tbl[4] = '{rst:0, wr:0, rd:1, din:8'h00, cnt:0, emp:1, ful:0, ovf:0, unf:1};
    tbl[5] = '{rst:0, wr:1, rd:1, din:8'h22, cnt:1, emp:0, ful:0, ovf:0, unf:1};
    tbl[6] = '{rst:1, wr:1, rd:0, din:8'h33, cnt:0, emp:1, ful:0, ovf:0, unf:0};

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
      tick();
      chk($sformatf("tbl%0d.count", i), 32'(bus.o_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(bus.o_fifo_empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i), 32'(bus.o_fifo_full), 32'(tbl[i].ful));
      chk($sformatf("tbl%0d.ovf", i), 32'(bus.o_overflow), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.unf", i), 32'(bus.o_underflow), 32'(tbl[i].unf));
      check_all($sformatf("tbl%0d", i));
    end
    chk("reset.rvalid", 32'(bus.rd_valid), 32'd0);
    chk("reset.rdata", 32'(bus.rd_data), 32'd0);

    // Single word latency
    drive(0, 1, 0, 8'h5C); tick(); check_all("lat.wr");
`ifdef SYNC_FIFO_FWFT_EN
    chk("lat.fwft_valid", 32'(bus.rd_valid), 32'd1);
    chk("lat.fwft_data", 32'(bus.rd_data), 32'h5C);
    drive(0, 0, 1, 8'h00); tick(); check_all("lat.rd");
    chk("lat.fwft_after", 32'(bus.rd_valid), 32'd0);
`else
    chk("lat.pre_valid", 32'(bus.rd_valid), 32'd0);
    drive(0, 0, 1, 8'h00); tick(); check_all("lat.rd");
    chk("lat.valid", 32'(bus.rd_valid), 32'd1);
    chk("lat.data", 32'(bus.rd_data), 32'h5C);
    drive(0, 0, 0, 8'h00); tick(); check_all("lat.idle");
    chk("lat.pulse_end", 32'(bus.rd_valid), 32'd0);
    chk("lat.hold", 32'(bus.rd_data), 32'h5C);
`endif

    // Fill to full, overflow, drain in order
    drive(1, 0, 0, 8'h00); tick();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 1, 0, 8'(i)); tick(); check_all("fill");
      chk($sformatf("fill%0d.afull", i), 32'(bus.o_almost_full), 32'(i >= 14));
    end
    chk("full.count", 32'(bus.o_count), 32'd16);
    chk("full.full", 32'(bus.o_fifo_full), 32'd1);
    chk("full.empty", 32'(bus.o_fifo_empty), 32'd0);
    drive(0, 1, 0, 8'hAA); tick(); check_all("ovf");
    chk("ovf.flag", 32'(bus.o_overflow), 32'd1);
    chk("ovf.count", 32'(bus.o_count), 32'd16);
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain%0d.head", i), 32'(bus.rd_data), 32'(i));
`endif
      drive(0, i == 1, 1, 8'hBB); tick(); check_all("drain");
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain%0d.data", i), 32'(bus.rd_data), 32'(i));
`endif
      if (i == 1) chk("full_wr_rd.count", 32'(bus.o_count), 32'd15);
      if (i == 1) begin
        drive(0, 0, 1, 8'h00);
      end
    end
    chk("drain.ovf_sticky", 32'(bus.o_overflow), 32'd1);
    drive(0, 0, 1, 8'h00); tick(); check_all("drain.tail");

    // Steady one-word occupancy across pointer wrap
    drive(1, 0, 0, 8'h00); tick();
    drive(0, 1, 0, 8'h00); tick(); check_all("pre");
    for (int k = 0; k < 40; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("stream%0d.head", k), 32'(bus.rd_data), 32'(k));
`endif
      drive(0, 1, 1, 8'(k + 1)); tick(); check_all("stream");
      chk($sformatf("stream%0d.count", k), 32'(bus.o_count), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("stream%0d.data", k), 32'(bus.rd_data), 32'(k));
`endif
    end

    // Reset mid-operation with a pending write
    drive(1, 0, 0, 8'h00); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 8'(8'hC0 + i)); tick();
    end
    drive(0, 0, 1, 8'h00); tick();
    drive(0, 1, 1, 8'hEE); tick();
    chk("mid.count", 32'(bus.o_count), 32'd4);
    drive(1, 1, 0, 8'hDD); tick(); check_all("rst_mid");
    chk("rst_mid.count", 32'(bus.o_count), 32'd0);
    chk("rst_mid.empty", 32'(bus.o_fifo_empty), 32'd1);
    chk("rst_mid.aempty", 32'(bus.o_almost_empty), 32'd1);
    chk("rst_mid.rvalid", 32'(bus.rd_valid), 32'd0);
    drive(0, 1, 0, 8'h77); tick(); check_all("post.wr");
    drive(0, 0, 1, 8'h00); tick(); check_all("post.rd");
    chk("post.count", 32'(bus.o_count), 32'd0);

    // Randomised traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 45), 8'($urandom));
      tick();
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
